// File: rtl/signed_divider_if.sv
// Handshake bundle for signed_divider: operand channel (in_*) and result
// channel (out_*). out_remainder is present only when DIV_REMAINDER_EN is
// defined, matching the divider's optional remainder output.
interface signed_divider_if #(
    parameter int DIVIDEND_WIDTH = 48,
    parameter int DIVISOR_WIDTH  = 24
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DIVIDEND_WIDTH-1:0] in_dividend;
    logic [DIVISOR_WIDTH-1:0]  in_divisor;
    logic                      out_valid;
    logic                      out_ready;
    logic [DIVIDEND_WIDTH-1:0] out_quotient;
`ifdef DIV_REMAINDER_EN
    logic [DIVISOR_WIDTH-1:0]  out_remainder;
`endif
    logic                      out_div_by_zero;
    logic                      out_overflow;

    // Producer/consumer side (drives operands, accepts results).
    modport master (
        output in_valid, in_dividend, in_divisor, out_ready,
        input  in_ready, out_valid, out_quotient,
`ifdef DIV_REMAINDER_EN
               out_remainder,
`endif
               out_div_by_zero, out_overflow
    );

    // Divider side.
    modport slave (
        input  in_valid, in_dividend, in_divisor, out_ready,
        output in_ready, out_valid, out_quotient,
`ifdef DIV_REMAINDER_EN
               out_remainder,
`endif
               out_div_by_zero, out_overflow
    );
endinterface

// File: rtl/signed_divider.sv
// Iterative signed divider: Q = N / D, R = N % D (truncation toward zero,
// remainder takes the dividend's sign). Restoring radix-2 on magnitudes,
// one quotient bit per cycle, followed by a sign fix-up cycle.
// Optional build macro: DIV_REMAINDER_EN -- when defined, the remainder
// output and its sign fix-up are built; otherwise only quotient and flags.
module signed_divider #(
    parameter int DIVIDEND_WIDTH = 48,
    parameter int DIVISOR_WIDTH  = 24
) (
    input  logic            clk,
    input  logic            resetn,
    signed_divider_if.slave bus
);
    localparam int NW = DIVIDEND_WIDTH;
    localparam int DW = DIVISOR_WIDTH;
    localparam int CW = (NW > 2) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Two's-complement negation at dividend width.
    function automatic logic [NW-1:0] neg_n(input logic [NW-1:0] v);
        return NW'(0) - v;
    endfunction

    // Two's-complement negation at divisor width.
    function automatic logic [DW-1:0] neg_d(input logic [DW-1:0] v);
        return DW'(0) - v;
    endfunction

    state_e          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [NW-1:0]   quot_q, quot_d;
    logic            dbz_q, dbz_d;
    logic            ovf_q, ovf_d;
    // a_q holds the remaining dividend magnitude bits in its upper part and
    // collects quotient bits from the bottom as they are produced.
    logic [NW-1:0]   a_q, a_d;
    logic [DW-1:0]   d_abs_q, d_abs_d;
    // Partial remainder is always < |D|, so DW bits hold it between cycles;
    // the shifted trial value needs the extra bit.
    logic [DW-1:0]   p_q, p_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_quo_q, neg_quo_d;
    logic            ovf_pend_q, ovf_pend_d;
`ifdef DIV_REMAINDER_EN
    logic [DW-1:0]   rem_q, rem_d;
    logic            neg_rem_q, neg_rem_d;
`endif

    logic            accept_s;
    logic [DW:0]     p_trial_s;
    logic [DW-1:0]   p_sub_s;
    logic            p_ge_s;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        quot_d      = quot_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        a_d         = a_q;
        d_abs_d     = d_abs_q;
        p_d         = p_q;
        cnt_d       = cnt_q;
        neg_quo_d   = neg_quo_q;
        ovf_pend_d  = ovf_pend_q;
`ifdef DIV_REMAINDER_EN
        rem_d       = rem_q;
        neg_rem_d   = neg_rem_q;
`endif

        // in_ready_q is only ever set while in IDLE.
        accept_s  = bus.in_valid && in_ready_q;
        p_trial_s = {p_q, a_q[NW-1]};
        p_ge_s    = (p_trial_s >= {1'b0, d_abs_q});
        p_sub_s   = p_trial_s[DW-1:0] - d_abs_q;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    if (bus.in_divisor == {DW{1'b0}}) begin
                        state_d = DONE;
                        quot_d  = {NW{1'b1}};
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
`ifdef DIV_REMAINDER_EN
                        rem_d   = bus.in_dividend[DW-1:0];
`endif
                    end else begin
                        state_d    = CALC;
                        a_d        = bus.in_dividend[NW-1] ? neg_n(bus.in_dividend) : bus.in_dividend;
                        d_abs_d    = bus.in_divisor[DW-1] ? neg_d(bus.in_divisor) : bus.in_divisor;
                        neg_quo_d  = bus.in_dividend[NW-1] ^ bus.in_divisor[DW-1];
                        ovf_pend_d = (bus.in_dividend == {1'b1, {(NW-1){1'b0}}}) &&
                                     (bus.in_divisor == {DW{1'b1}});
                        cnt_d      = CW'(NW - 1);
                        p_d        = {DW{1'b0}};
`ifdef DIV_REMAINDER_EN
                        neg_rem_d  = bus.in_dividend[NW-1];
`endif
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (p_ge_s) begin
                    p_d = p_sub_s;
                    a_d = {a_q[NW-2:0], 1'b1};
                end else begin
                    p_d = p_trial_s[DW-1:0];
                    a_d = {a_q[NW-2:0], 1'b0};
                end
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIX: begin
                // The -2^(NW-1) / -1 case wraps naturally: magnitude 2^(NW-1)
                // with a positive sign reads back as -2^(NW-1).
                quot_d  = neg_quo_q ? neg_n(a_q) : a_q;
                dbz_d   = 1'b0;
                ovf_d   = ovf_pend_q;
                state_d = DONE;
`ifdef DIV_REMAINDER_EN
                rem_d   = neg_rem_q ? neg_d(p_q) : p_q;
`endif
            end
            DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // out_valid trails entry into DONE by one cycle and drops on hand-off.
        out_valid_d = (state_q == DONE) && !(out_valid_q && bus.out_ready);
        in_ready_d  = (state_d == IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            quot_q      <= {NW{1'b0}};
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            a_q         <= {NW{1'b0}};
            d_abs_q     <= {DW{1'b0}};
            p_q         <= {DW{1'b0}};
            cnt_q       <= {CW{1'b0}};
            neg_quo_q   <= 1'b0;
            ovf_pend_q  <= 1'b0;
`ifdef DIV_REMAINDER_EN
            rem_q       <= {DW{1'b0}};
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            quot_q      <= quot_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            a_q         <= a_d;
            d_abs_q     <= d_abs_d;
            p_q         <= p_d;
            cnt_q       <= cnt_d;
            neg_quo_q   <= neg_quo_d;
            ovf_pend_q  <= ovf_pend_d;
`ifdef DIV_REMAINDER_EN
            rem_q       <= rem_d;
            neg_rem_q   <= neg_rem_d;
`endif
        end
    end

    assign bus.in_ready        = in_ready_q;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_quotient    = quot_q;
    assign bus.out_div_by_zero = dbz_q;
    assign bus.out_overflow    = ovf_q;
`ifdef DIV_REMAINDER_EN
    assign bus.out_remainder   = rem_q;
`endif

endmodule
